apb_slave_regs: RTL

APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

---
 rtl/apb_slave_regs.sv | 134 +++++++++++++
 1 files changed

// File: rtl/apb_slave_regs.sv
// APB register slave: eight general registers, a DATA register and two transfer counters.
// Every ACCESS phase is stretched by WAIT_CYCLES; protocol violations raise a sticky flag.
module apb_slave_regs #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic       pclk,
    input  logic       preset_n,
    input  logic       psel_i,
    input  logic       penable_i,
    input  logic [7:0] paddr_i,
    input  logic       pwrite_i,
    input  logic [7:0] pwdata_i,
    output logic [7:0] prdata_o,
    output logic       pready_o,
    output logic       pslverr_o,
    output logic       proto_err_o
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    localparam logic [3:0] WaitLast = 4'(WAIT_CYCLES);

    state_e     state_q, state_d;
    logic [7:0] addr_q;
    logic       write_q;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       proto_err_q, proto_err_d;
    logic [7:0] regs_q [8];
    logic [7:0] data_q;
    logic [7:0] wr_cnt_q;
    logic [7:0] rd_cnt_q;

    logic       latch;
    logic       complete;
    logic       is_cnt;
    logic       mapped;
    logic       err;
    logic [7:0] rd_val;

    // Decode works only on the latched address, so ACCESS-phase address changes are ignored.
    assign is_cnt = (addr_q == 8'hF0) || (addr_q == 8'hF1);
    assign mapped = (addr_q < 8'h08) || (addr_q == 8'hAB) || is_cnt;
    assign err    = !mapped || (write_q && is_cnt);

    always_comb begin
        rd_val = 8'h00;
        if (addr_q < 8'h08) begin
            rd_val = regs_q[addr_q[2:0]];
        end else if (addr_q == 8'hAB) begin
            rd_val = data_q;
        end else if (addr_q == 8'hF0) begin
            rd_val = wr_cnt_q;
        end else if (addr_q == 8'hF1) begin
            rd_val = rd_cnt_q;
        end
    end

    assign pready_o    = (state_q == StAccess) && (wait_cnt_q == WaitLast);
    assign pslverr_o   = pready_o && err;
    assign prdata_o    = (pready_o && !write_q && !err) ? rd_val : 8'h00;
    assign proto_err_o = proto_err_q;
    assign complete    = pready_o && psel_i && penable_i;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        proto_err_d = proto_err_q;
        latch       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (psel_i && !penable_i) begin
                    latch      = 1'b1;
                    wait_cnt_d = 4'd0;
                    state_d    = StAccess;
                end else if (psel_i && penable_i) begin
                    proto_err_d = 1'b1;
                end
            end
            StAccess: begin
                if (!psel_i || !penable_i) begin
                    proto_err_d = 1'b1;
                    state_d     = StIdle;
                end else if (pready_o) begin
                    state_d = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q     <= StIdle;
            addr_q      <= 8'h00;
            write_q     <= 1'b0;
            wait_cnt_q  <= 4'd0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            proto_err_q <= proto_err_d;
            if (latch) begin
                addr_q  <= paddr_i;
                write_q <= pwrite_i;
            end
        end
    end

    // Erroneous completions leave registers and counters untouched.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 8'h00;
            end
            data_q   <= 8'h00;
            wr_cnt_q <= 8'h00;
            rd_cnt_q <= 8'h00;
        end else if (complete && !err) begin
            if (write_q) begin
                if (addr_q < 8'h08) begin
                    regs_q[addr_q[2:0]] <= pwdata_i;
                end else begin
                    data_q <= pwdata_i;
                end
                wr_cnt_q <= wr_cnt_q + 8'd1;
            end else begin
                rd_cnt_q <= rd_cnt_q + 8'd1;
            end
        end
    end

endmodule
